// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Program-fetch sequencer with a one-cycle-latency program memory and a
//   circular return-address stack. It drives the memory address/read/flush
//   controls, tracks which memory output word is a real instruction
//   (instr_valid) and its address (exec_pc), and performs goto, call,
//   return and skip redirects.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   BOOT  | first cycle after reset: fetch address 0
//   RUN   | sequential fetch; redirects and skips are accepted here
//   FLUSH | fetch the redirect target while the flushed nop drains
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   stall             hold request: freezes everything, blocks memory access
//   branch_valid      goto to branch_target
//   branch_target     goto/call destination
//   call, ret, skip   call (push return address), return (pop), skip next word
//   mem_addr          program memory address (the fetch address register)
//   mem_rd_en         program memory read enable
//   mem_flush         forces the next memory output word to nop
//   instr_valid       memory output this cycle is an instruction to execute
//   exec_pc           address of the word on the memory output
//   stack_overflow    sticky: a call pushed onto a full stack
//   stack_underflow   sticky: a return popped an empty stack
module fetch_sequencer #(
  parameter int ADDR_WIDTH  = 13,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  skip,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_flush,
  output logic                  instr_valid,
  output logic [ADDR_WIDTH-1:0] exec_pc,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam logic [PTR_W:0] DEPTH_FULL = (PTR_W+1)'(STACK_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_addr, fetch_nxt;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]      sp;
  logic [PTR_W-1:0]      sp_top;
  logic [PTR_W:0]        depth;
  logic                  push, pop;

  assign mem_addr = fetch_addr;
  // sp points at the next free slot; the top entry sits one below it and the
  // subtraction wraps, which is what gives an empty-stack pop its address.
  assign sp_top   = sp - PTR_W'(1);

  always_comb begin
    state_nxt = state;
    fetch_nxt = fetch_addr;
    mem_rd_en = 1'b0;
    mem_flush = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (!rst && !stall) begin
      case (state)
        BOOT: begin
          mem_rd_en = 1'b1;
          fetch_nxt = ADDR_WIDTH'(1);
          state_nxt = RUN;
        end
        RUN: begin
          if (ret) begin
            pop       = 1'b1;
            mem_flush = 1'b1;
            fetch_nxt = stack_mem[sp_top];
            state_nxt = FLUSH;
          end else if (call) begin
            push      = 1'b1;
            mem_flush = 1'b1;
            fetch_nxt = branch_target;
            state_nxt = FLUSH;
          end else if (branch_valid) begin
            mem_flush = 1'b1;
            fetch_nxt = branch_target;
            state_nxt = FLUSH;
          end else if (skip) begin
            // The word after the skip instruction is being fetched right now;
            // flushing it and stepping on means it is never presented.
            mem_flush = 1'b1;
            fetch_nxt = fetch_addr + ADDR_WIDTH'(1);
          end else begin
            mem_rd_en = 1'b1;
            fetch_nxt = fetch_addr + ADDR_WIDTH'(1);
          end
        end
        FLUSH: begin
          mem_rd_en = 1'b1;
          fetch_nxt = fetch_addr + ADDR_WIDTH'(1);
          state_nxt = RUN;
        end
        default: begin
          state_nxt = BOOT;
          fetch_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= BOOT;
      fetch_addr      <= '0;
      exec_pc         <= '0;
      instr_valid     <= 1'b0;
      sp              <= '0;
      depth           <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      state       <= state_nxt;
      fetch_addr  <= fetch_nxt;
      instr_valid <= mem_rd_en & ~mem_flush;
      exec_pc     <= fetch_addr;
      if (push) begin
        sp <= sp + PTR_W'(1);
        if (depth == DEPTH_FULL) stack_overflow <= 1'b1;
        else                     depth <= depth + (PTR_W+1)'(1);
      end else if (pop) begin
        sp <= sp_top;
        if (depth == '0) stack_underflow <= 1'b1;
        else             depth <= depth - (PTR_W+1)'(1);
      end
    end
  end

  // Stack storage carries no reset; an empty-stack pop simply returns
  // whatever the wrapped slot holds.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp] <= exec_pc + ADDR_WIDTH'(1);
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
  localparam int AW  = 13;
  localparam int STK = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0, branch_valid = 1'b0, call = 1'b0, ret = 1'b0, skip = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] mem_addr, exec_pc;
  logic          mem_rd_en, mem_flush, instr_valid, stack_overflow, stack_underflow;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_sequencer #(.ADDR_WIDTH(AW), .STACK_DEPTH(STK)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .call(call), .ret(ret), .skip(skip),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_flush(mem_flush),
    .instr_valid(instr_valid), .exec_pc(exec_pc),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic br, input logic ca,
                       input logic re, input logic sk, input logic [AW-1:0] tg);
    stall = st; branch_valid = br; call = ca; ret = re; skip = sk; branch_target = tg;
  endtask

  task automatic reset_dut();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset, then advance until exec_pc == pc is the valid instruction.
  task automatic run_to(input int pc);
    reset_dut();
    tick();
    repeat (pc) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", instr_valid); else n_pass++;
    n_checks++; if (exec_pc !== 13'h0) $display("FAIL rst_exec_pc: got %h want 0", exec_pc); else n_pass++;
    n_checks++; if (mem_addr !== 13'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
    n_checks++; if ({mem_rd_en, mem_flush} !== 2'b00) $display("FAIL rst_rd_flush: got %b want 00", {mem_rd_en, mem_flush}); else n_pass++;
    n_checks++; if ({stack_overflow, stack_underflow} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {stack_overflow, stack_underflow}); else n_pass++;
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h055);  // goto during BOOT is ignored
    #1;
    n_checks++; if ({mem_rd_en, mem_flush} !== 2'b10) $display("FAIL boot_rd_flush: got %b want 10", {mem_rd_en, mem_flush}); else n_pass++;
    n_checks++; if (mem_addr !== 13'h0) $display("FAIL boot_mem_addr: got %h want 0", mem_addr); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h0}) $display("FAIL boot_first: got v=%b pc=%h want v=1 pc=0", instr_valid, exec_pc); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'(k)}) $display("FAIL seq_pc: got v=%b pc=%h want v=1 pc=%h", instr_valid, exec_pc, 13'(k)); else n_pass++;
    end
  endtask

  task automatic test_branch();
    run_to(5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h001);
    #1;
    n_checks++; if ({mem_rd_en, mem_flush} !== 2'b01) $display("FAIL br_rd_flush: got %b want 01", {mem_rd_en, mem_flush}); else n_pass++;
    tick();
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL br_bubble: got %b want 0", instr_valid); else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0AA);  // goto during FLUSH is ignored
    #1;
    n_checks++; if ({mem_rd_en, mem_flush, mem_addr} !== {2'b10, 13'h001}) $display("FAIL br_flush_cycle: got rd/fl=%b%b addr=%h want 10 001", mem_rd_en, mem_flush, mem_addr); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h001}) $display("FAIL br_target: got v=%b pc=%h want v=1 pc=001", instr_valid, exec_pc); else n_pass++;
    tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h002}) $display("FAIL br_after: got v=%b pc=%h want v=1 pc=002", instr_valid, exec_pc); else n_pass++;
  endtask

  task automatic test_call_ret();
    run_to(16);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h100}) $display("FAIL call_target: got v=%b pc=%h want v=1 pc=100", instr_valid, exec_pc); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h1234);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if ({instr_valid, mem_addr} !== {1'b0, 13'h011}) $display("FAIL ret_bubble: got v=%b addr=%h want v=0 addr=011", instr_valid, mem_addr); else n_pass++;
    tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h011}) $display("FAIL ret_target: got v=%b pc=%h want v=1 pc=011", instr_valid, exec_pc); else n_pass++;
  endtask

  task automatic test_stack_overflow();
    logic [AW-1:0] pushed [9];
    logic [AW-1:0] cur, tgt, want;
    run_to(0);
    cur = '0;
    for (int k = 0; k < 9; k++) begin
      tgt = 13'h200 + 13'(k * 16);
      pushed[k] = cur + 13'd1;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, tgt);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      n_checks++; if (stack_overflow !== (k == 8)) $display("FAIL ovf_call%0d: got %b want %b", k, stack_overflow, (k == 8)); else n_pass++;
      tick();
      n_checks++; if ({instr_valid, exec_pc} !== {1'b1, tgt}) $display("FAIL call%0d_target: got v=%b pc=%h want v=1 pc=%h", k, instr_valid, exec_pc, tgt); else n_pass++;
      cur = tgt;
    end
    // Nine pushes into eight slots: the first return address is lost, and
    // the ninth pop wraps back onto the slot holding the newest address.
    for (int j = 0; j < 9; j++) begin
      want = (j < 8) ? pushed[8 - j] : pushed[8];
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      n_checks++; if (stack_underflow !== (j == 8)) $display("FAIL unf_ret%0d: got %b want %b", j, stack_underflow, (j == 8)); else n_pass++;
      tick();
      n_checks++; if ({instr_valid, exec_pc} !== {1'b1, want}) $display("FAIL ret%0d_addr: got v=%b pc=%h want v=1 pc=%h", j, instr_valid, exec_pc, want); else n_pass++;
    end
    n_checks++; if (stack_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", stack_overflow); else n_pass++;
  endtask

  task automatic test_skip();
    run_to(32);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    #1;
    n_checks++; if ({mem_rd_en, mem_flush} !== 2'b01) $display("FAIL skip_rd_flush: got %b want 01", {mem_rd_en, mem_flush}); else n_pass++;
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    n_checks++; if ({instr_valid, exec_pc} !== {1'b0, 13'h021}) $display("FAIL skip_hidden: got v=%b pc=%h want v=0 pc=021", instr_valid, exec_pc); else n_pass++;
    tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h022}) $display("FAIL skip_next: got v=%b pc=%h want v=1 pc=022", instr_valid, exec_pc); else n_pass++;
  endtask

  task automatic test_priority();
    run_to(4);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'h300);   // push 0x005
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 13'h400);   // ret wins
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h005}) $display("FAIL prio_ret: got v=%b pc=%h want v=1 pc=005", instr_valid, exec_pc); else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h500);   // call wins, pushes 0x006
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h500}) $display("FAIL prio_call: got v=%b pc=%h want v=1 pc=500", instr_valid, exec_pc); else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 13'h600);   // goto wins over skip
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h600}) $display("FAIL prio_branch: got v=%b pc=%h want v=1 pc=600", instr_valid, exec_pc); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h006}) $display("FAIL prio_ret2: got v=%b pc=%h want v=1 pc=006", instr_valid, exec_pc); else n_pass++;
  endtask

  task automatic test_stall_wrap();
    run_to(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h1FFD);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0); tick(); tick();
    n_checks++; if ({instr_valid, exec_pc, mem_addr} !== {1'b1, 13'h1FFE, 13'h1FFF}) $display("FAIL wrap_setup: got v=%b pc=%h addr=%h want 1 1ffe 1fff", instr_valid, exec_pc, mem_addr); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 13'h123);  // stall beats every redirect
      #1;
      n_checks++; if ({mem_rd_en, mem_flush} !== 2'b00) $display("FAIL stall_rd_flush%0d: got %b want 00", k, {mem_rd_en, mem_flush}); else n_pass++;
      tick();
      n_checks++; if ({instr_valid, exec_pc, mem_addr} !== {1'b1, 13'h1FFE, 13'h1FFF}) $display("FAIL stall_frozen%0d: got v=%b pc=%h addr=%h want 1 1ffe 1fff", k, instr_valid, exec_pc, mem_addr); else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    n_checks++; if ({instr_valid, exec_pc, mem_addr} !== {1'b1, 13'h1FFF, 13'h0000}) $display("FAIL wrap_addr: got v=%b pc=%h addr=%h want 1 1fff 0000", instr_valid, exec_pc, mem_addr); else n_pass++;
    tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h0000}) $display("FAIL wrap_pc: got v=%b pc=%h want v=1 pc=0000", instr_valid, exec_pc); else n_pass++;
  endtask

  task automatic test_reset_mid();
    run_to(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h040);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    n_checks++; if ({mem_rd_en, mem_flush} !== 2'b00) $display("FAIL midrst_rd_flush: got %b want 00", {mem_rd_en, mem_flush}); else n_pass++;
    tick();
    n_checks++; if ({instr_valid, exec_pc, mem_addr} !== {1'b0, 13'h0, 13'h0}) $display("FAIL midrst_state: got v=%b pc=%h addr=%h want 0 0 0", instr_valid, exec_pc, mem_addr); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if ({instr_valid, exec_pc} !== {1'b1, 13'h0}) $display("FAIL midrst_boot: got v=%b pc=%h want v=1 pc=0", instr_valid, exec_pc); else n_pass++;
  endtask

  // Instruction-stream model: each executed instruction at pc either falls
  // through to pc+1, or costs one invalid cycle (showing pc+1) before its
  // destination appears. Returns live in a queue; overflow drops the oldest.
  task automatic test_random();
    logic [AW-1:0] rstack [$];
    logic          m_valid, m_ovf, st, br, ca, re, sk, any;
    logic [AW-1:0] m_pc, m_up, tg, dest, want_addr;
    reset_dut();
    m_valid = 1'b0; m_pc = '0; m_up = '0; m_ovf = 1'b0;
    for (int i = 0; i < 800; i++) begin
      st = ($urandom_range(0, 6) == 0);
      br = m_valid && ($urandom_range(0, 7) == 0);
      ca = m_valid && ($urandom_range(0, 6) == 0);
      re = m_valid && (rstack.size() > 0) && ($urandom_range(0, 5) == 0);
      sk = m_valid && ($urandom_range(0, 7) == 0);
      tg = AW'($urandom);
      any = br | ca | re | sk;
      drive(st, br, ca, re, sk, tg);
      #1;
      n_checks++; if ({mem_rd_en, mem_flush} !== {~st & ~any, ~st & any}) $display("FAIL rnd_rd_flush[%0d]: got %b%b want %b%b", i, mem_rd_en, mem_flush, ~st & ~any, ~st & any); else n_pass++;
      if (!st) begin
        if (any) begin
          if (re) dest = rstack.pop_back();
          else if (ca) begin
            rstack.push_back(m_pc + 13'd1);
            if (rstack.size() > STK) begin
              void'(rstack.pop_front());
              m_ovf = 1'b1;
            end
            dest = tg;
          end
          else if (br) dest = tg;
          else dest = m_pc + 13'd2;
          m_valid = 1'b0; m_pc = m_pc + 13'd1; m_up = dest;
        end else if (m_valid) m_pc = m_pc + 13'd1;
        else begin
          m_valid = 1'b1; m_pc = m_up;
        end
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
      want_addr = m_valid ? m_pc + 13'd1 : m_up;
      n_checks++; if ({instr_valid, exec_pc} !== {m_valid, m_pc}) $display("FAIL rnd_exec[%0d]: got v=%b pc=%h want v=%b pc=%h", i, instr_valid, exec_pc, m_valid, m_pc); else n_pass++;
      n_checks++; if (mem_addr !== want_addr) $display("FAIL rnd_addr[%0d]: got %h want %h", i, mem_addr, want_addr); else n_pass++;
      n_checks++; if ({stack_overflow, stack_underflow} !== {m_ovf, 1'b0}) $display("FAIL rnd_flags[%0d]: got %b%b want %b0", i, stack_overflow, stack_underflow, m_ovf); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_stack_overflow();
    test_skip();
    test_priority();
    test_stall_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13: program address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 8: return-stack entries (power of two).
REQ-003 SHALL have clk  input  1: clock, all state updates on rising edge.
REQ-004 SHALL have rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have stall  input  1: core hold request.
REQ-006 SHALL have branch_valid  input  1: executing goto, redirect to branch_target.
REQ-007 SHALL have branch_target  input  ADDR_WIDTH: goto/call destination.
REQ-008 SHALL have call  input  1: executing call: push return address, redirect to branch_target.
REQ-009 SHALL have ret  input  1: executing return: pop stack, redirect to popped address.
REQ-010 SHALL have skip  input  1: executing skip-type instruction: discard the next instruction.
REQ-011 SHALL have mem_addr  output  ADDR_WIDTH: program memory address, equals fetch_addr register.
REQ-012 SHALL have mem_rd_en  output  1: program memory read enable (combinational).
REQ-013 SHALL have mem_flush  output  1: program memory flush, forces next memory output to nop 0x0000 (combinational).
REQ-014 SHALL have instr_valid  output  1: memory output this cycle is an instruction to execute.
REQ-015 SHALL have exec_pc  output  ADDR_WIDTH: address of the instruction on the memory output.
REQ-016 SHALL have stack_overflow, stack_underflow  output  1 each: sticky error flags.

Function
REQ-017 SHALL implement states BOOT, RUN, FLUSH; memory read latency is one cycle.
REQ-018 In BOOT (first cycle after rst release), SHALL assert mem_rd_en, mem_addr=0, fetch_addr<=1, next state RUN.
REQ-019 In RUN with no redirect/skip, SHALL assert mem_rd_en, fetch_addr<=fetch_addr+1 modulo 2^ADDR_WIDTH (0x1FFF wraps to 0x0000).
REQ-020 Redirect priority SHALL be ret > call > branch_valid > skip; lower-priority inputs ignored that cycle.
REQ-021 Redirect cycle (ret/call/branch_valid in RUN): mem_rd_en=0, mem_flush=1, fetch_addr<=target, next state FLUSH.
REQ-022 In FLUSH, SHALL assert mem_rd_en at target, fetch_addr<=target+1, next state RUN; the taken branch costs 2 cycles from redirect to valid target instruction.
REQ-023 Redirect/skip inputs in BOOT or FLUSH SHALL be ignored.
REQ-024 Skip in RUN: mem_flush=1, mem_rd_en=0, fetch_addr<=fetch_addr+1 (skipped word is never presented), state stays RUN.
REQ-025 call SHALL push exec_pc+1 (modulo 2^ADDR_WIDTH) and redirect to branch_target.
REQ-026 ret SHALL pop top entry and redirect to it.
REQ-027 Stack SHALL be circular: push when full overwrites oldest entry and sets stack_overflow; pop when empty returns the entry at the wrapped pointer, redirects there, and sets stack_underflow; depth count saturates at 0 and STACK_DEPTH.
REQ-028 instr_valid SHALL register (mem_rd_en & ~mem_flush) and exec_pc SHALL register mem_addr, both only on non-stalled cycles.
REQ-029 stall=1 SHALL force mem_rd_en=0, mem_flush=0, and freeze state, fetch_addr, stack, instr_valid, exec_pc; all redirect inputs ignored.
REQ-030 Stall SHALL take precedence over every redirect in the same cycle.

Reset
REQ-031 rst SHALL force next-cycle values: state BOOT, fetch_addr 0, exec_pc 0, instr_valid 0, stack pointer and depth 0, both flags 0; mem_rd_en=0 and mem_flush=0 while rst is high.
REQ-032 rst mid-redirect or mid-stall SHALL abandon the operation; stack contents need not be cleared.

Verification
REQ-033 Release rst -> cycle 1 mem_addr 0 rd_en 1; cycle 2 instr_valid 1 exec_pc 0; exec_pc increments 1,2,3 each cycle.
REQ-034 branch_valid with target 0x001 when exec_pc=5 -> mem_flush 1, next cycle instr_valid 0 and instr 0x0000, following cycle exec_pc 0x001 instr_valid 1.
REQ-035 call to 0x100 at exec_pc 0x010, then ret -> stack returns 0x011; exec_pc 0x011 valid two cycles after ret.
REQ-036 Nine consecutive calls then nine rets -> stack_overflow 1 after 9th call; first ret returns 9th address; stack_underflow 1 on 9th ret.
REQ-037 skip at exec_pc 0x020 -> exec_pc 0x021 never valid; next valid exec_pc 0x022.
REQ-038 fetch_addr 0x1FFF with stall held 3 cycles then released -> outputs frozen during stall; then mem_addr wraps to 0x0000.
